sort4_compare_ctrl: RTL and testbench

SORT4_COMPARE_CTRL -- requirements
Module: sort4_compare_ctrl

---
 rtl/sort4_compare_ctrl.sv | 136 +++++++++++++
 tb/tb_sort4_compare_ctrl.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/sort4_compare_ctrl.sv
// Four-byte bubble sorter with a single shared 8-bit magnitude comparator.
// One compare per CMP cycle, early exit when a pass makes no swap.

module compare8_assign (
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic       re,
  output logic       reb,
  output logic       eq
);
  assign re  = (a > b);
  assign reb = (a < b);
  assign eq  = (a == b);
endmodule

module sort4_compare_ctrl #(
  parameter bit ASCEND = 1'b1
) (
  input  logic        clock,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] din,
  output logic        busy,
  output logic        done,
  output logic [31:0] dout,
  output logic [2:0]  swap_cnt
);

  typedef enum logic [1:0] {IDLE, CMP, DONE} state_t;

  state_t          state, state_nxt;
  logic [3:0][7:0] elems;
  logic [3:0][7:0] swapped_elems;
  logic [1:0]      pass;
  logic [1:0]      j;
  logic [1:0]      j_right;
  logic            pass_swap;
  logic [2:0]      cnt;
  logic [7:0]      left, right;
  logic            re, reb, eq;
  logic            do_swap;
  logic            last_cmp;
  logic            pass_dirty;
  logic            finish;

  compare8_assign u_cmp (
    .a   (left),
    .b   (right),
    .re  (re),
    .reb (reb),
    .eq  (eq)
  );

  // Select the current pair, decide the swap and form the post-compare element set.
  always_comb begin
    j_right       = j + 2'd1;
    left          = elems[j];
    right         = elems[j_right];
    do_swap       = (ASCEND ? re : reb) & ~eq;
    last_cmp      = (j == (2'd3 - pass));
    pass_dirty    = pass_swap | do_swap;
    finish        = last_cmp & (~pass_dirty | (pass == 2'd3));
    swapped_elems = elems;
    if (do_swap) begin
      swapped_elems[j]       = right;
      swapped_elems[j_right] = left;
    end
  end

  // State register.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and status outputs.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = CMP;
      CMP: begin
        busy = 1'b1;
        if (finish) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Element registers, pass/pair bookkeeping and result capture.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      elems     <= '0;
      pass      <= '0;
      j         <= '0;
      pass_swap <= 1'b0;
      cnt       <= '0;
      dout      <= '0;
      swap_cnt  <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          elems     <= din;
          cnt       <= '0;
          pass_swap <= 1'b0;
          pass      <= 2'd1;
          j         <= '0;
        end
        CMP: begin
          elems <= swapped_elems;
          cnt   <= cnt + {2'b00, do_swap};
          if (last_cmp) begin
            if (finish) begin
              dout     <= swapped_elems;
              swap_cnt <= cnt + {2'b00, do_swap};
            end else begin
              pass      <= pass + 2'd1;
              j         <= '0;
              pass_swap <= 1'b0;
            end
          end else begin
            j         <= j + 2'd1;
            pass_swap <= pass_dirty;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sort4_compare_ctrl.sv
// Directed and random checks of sort4_compare_ctrl in both sort directions,
// using a queue of expected results popped at each done pulse.

module tb_sort4_compare_ctrl;

  typedef struct packed {
    logic [3:0]  ncmp;
    logic [2:0]  swaps;
    logic [31:0] data;
  } exp_t;

  logic        clock;
  logic        rst_n;
  logic        start_a, start_d;
  logic [31:0] din_a, din_d;
  logic        busy_a, busy_d, done_a, done_d;
  logic [31:0] dout_a, dout_d;
  logic [2:0]  swap_cnt_a, swap_cnt_d;

  bit          sel;
  logic        busy_s, done_s;
  logic [31:0] dout_s;
  logic [2:0]  swap_cnt_s;

  int unsigned tests;
  int unsigned failed;
  exp_t        sb[$];

  sort4_compare_ctrl #(.ASCEND(1'b1)) dut_asc (
    .clock(clock), .rst_n(rst_n), .start(start_a), .din(din_a),
    .busy(busy_a), .done(done_a), .dout(dout_a), .swap_cnt(swap_cnt_a)
  );

  sort4_compare_ctrl #(.ASCEND(1'b0)) dut_desc (
    .clock(clock), .rst_n(rst_n), .start(start_d), .din(din_d),
    .busy(busy_d), .done(done_d), .dout(dout_d), .swap_cnt(swap_cnt_d)
  );

  assign busy_s     = sel ? busy_a     : busy_d;
  assign done_s     = sel ? done_a     : done_d;
  assign dout_s     = sel ? dout_a     : dout_d;
  assign swap_cnt_s = sel ? swap_cnt_a : swap_cnt_d;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, failed);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit s, input logic st, input logic [31:0] d);
    if (s) begin start_a = st; din_a = d; end
    else   begin start_d = st; din_d = d; end
  endtask

  // Bubble sort reference: swap count, compare-cycle count and result.
  function automatic exp_t model(input logic [31:0] d, input bit asc);
    logic [7:0] v[4];
    logic [7:0] t;
    bit         flag;
    bit         sw;
    exp_t       r;
    r = '0;
    for (int i = 0; i < 4; i++) v[i] = d[8*i +: 8];
    for (int p = 1; p <= 3; p++) begin
      flag = 1'b0;
      for (int k = 0; k <= 3 - p; k++) begin
        r.ncmp = r.ncmp + 4'd1;
        sw = asc ? (v[k] > v[k+1]) : (v[k] < v[k+1]);
        if (sw) begin
          t = v[k]; v[k] = v[k+1]; v[k+1] = t;
          r.swaps = r.swaps + 3'd1;
          flag = 1'b1;
        end
      end
      if (!flag) break;
    end
    r.data = {v[3], v[2], v[1], v[0]};
    return r;
  endfunction

  task automatic run_sort(input bit s, input logic [31:0] d, input logic [31:0] xd,
                          input logic [2:0] xs, input int unsigned xn, input bit hold);
    exp_t        e;
    int unsigned n;
    bit          seen;
    sb.push_back('{ncmp: xn[3:0], swaps: xs, data: xd});
    @(negedge clock);
    sel = s;
    drive(s, 1'b1, d);
    @(posedge clock); #1;
    check("busy_after_start", {31'b0, busy_s}, 32'd1);
    drive(s, hold, 32'hFFFFFFFF);
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 20) begin
      @(posedge clock); #1;
      n++;
      if (done_s) seen = 1'b1;
    end
    check("done_seen", {31'b0, seen}, 32'd1);
    e = sb.pop_front();
    if (seen) begin
      check("latency", n, {28'b0, e.ncmp});
      check("dout", dout_s, e.data);
      check("swap_cnt", {29'b0, swap_cnt_s}, {29'b0, e.swaps});
      check("busy_in_done", {31'b0, busy_s}, 32'd0);
      drive(s, 1'b0, 32'h0);
    end
    for (int c = 0; c < 3; c++) begin
      @(posedge clock); #1;
      check("done_single_pulse", {31'b0, done_s}, 32'd0);
      check("busy_idle", {31'b0, busy_s}, 32'd0);
    end
    check("dout_held", dout_s, e.data);
  endtask

  initial begin
    exp_t        x;
    logic [31:0] d;
    bit          s;
    tests   = 0;
    failed  = 0;
    sel     = 1'b1;
    start_a = 1'b0;
    start_d = 1'b0;
    din_a   = '0;
    din_d   = '0;
    rst_n   = 1'b0;
    #12;
    check("rst_busy_a", {31'b0, busy_a}, 32'd0);
    check("rst_done_a", {31'b0, done_a}, 32'd0);
    check("rst_dout_a", dout_a, 32'd0);
    check("rst_swap_a", {29'b0, swap_cnt_a}, 32'd0);
    check("rst_dout_d", dout_d, 32'd0);
    @(negedge clock);
    rst_n = 1'b1;

    run_sort(1'b1, 32'h04030201, 32'h04030201, 3'd0, 3, 1'b0);
    run_sort(1'b1, 32'h01020304, 32'h04030201, 3'd6, 6, 1'b0);
    run_sort(1'b1, 32'h55555555, 32'h55555555, 3'd0, 3, 1'b0);
    run_sort(1'b0, 32'h04030201, 32'h01020304, 3'd6, 6, 1'b0);
    run_sort(1'b0, 32'h01020304, 32'h01020304, 3'd0, 3, 1'b0);
    run_sort(1'b1, 32'h01020304, 32'h04030201, 3'd6, 6, 1'b1);
    run_sort(1'b1, 32'h02030401, 32'h04030201, 3'd3, 6, 1'b0);

    // Abort a sort with reset in its second compare cycle.
    @(negedge clock);
    sel = 1'b1;
    drive(1'b1, 1'b1, 32'h01020304);
    @(posedge clock); #1;
    drive(1'b1, 1'b0, 32'h0);
    @(posedge clock); #2;
    rst_n = 1'b0;
    #1;
    check("abort_busy", {31'b0, busy_a}, 32'd0);
    check("abort_done", {31'b0, done_a}, 32'd0);
    check("abort_dout", dout_a, 32'd0);
    check("abort_swap_cnt", {29'b0, swap_cnt_a}, 32'd0);
    @(negedge clock);
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(posedge clock); #1;
      check("abort_no_done", {31'b0, done_a}, 32'd0);
      check("abort_dout_zero", dout_a, 32'd0);
    end
    run_sort(1'b1, 32'h02010403, 32'h04030201, 3'd4, 6, 1'b0);

    for (int i = 0; i < 200; i++) begin
      d = $urandom;
      if (i % 4 == 0) d = {d[7:0], d[15:8], d[7:0], d[23:16]};
      s = (i % 2 == 0);
      x = model(d, s);
      run_sort(s, d, x.data, x.swaps, {28'b0, x.ncmp}, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
